tmem_responder: RTL

- Synthesizable tagged-memory responder: the memory end of the CPU bus protocol (address strobe, read, write, force-write).
- Latches a 20-bit physical address on the address strobe, then serves up to BURST sequential read/write strobes (block transfer) from an internal tagged RAM.
- Enforces tag-based write protection and flags protocol errors.
- Sits between the cpu module and the testbench/board, replacing the behavioural RAM model for synthesis.

---
 rtl/tmem_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/tmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tmem_responder
//  Purpose  : Tagged-memory responder, the memory end of the CPU bus.
//             An address strobe latches a word address; up to BURST read or
//             write strobes then access consecutive words, wrapping inside
//             the aligned BURST block. Each word carries an 8-bit tag. A set
//             tag bit PROT_BIT blocks normal writes, and i_wforce overrides it.
//  Options  : TMEM_RDMWR_EN - rd+wr together in ARMED performs a
//             read-modify-write: the old word is returned, then written back
//             with bit 56 set. Without the macro, rd+wr is a protocol error.
//  Revision : 1.0 - initial release
// ============================================================================
module tmem_responder #(
    parameter int ADDR_W   = 20,
    parameter int BURST    = 4,
    parameter int PROT_BIT = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] i_ad,
    input  logic [7:0]  i_tag,
    input  logic        i_astb,
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic        i_wforce,
    output logic [63:0] o_data,
    output logic [7:0]  o_tag,
    output logic        o_rvalid,
    output logic        o_wprot,
    output logic        o_err
);

    localparam int c_IDX_W = (BURST > 1) ? $clog2(BURST) : 0;
    localparam int c_CNT_W = $clog2(BURST + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BURST - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [63:0]        c_RMW_MASK = 64'h0100_0000_0000_0000;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [71:0]         r_mem [0:(2**ADDR_W)-1];

    logic [71:0]         w_word;
    logic                w_armed_free;
    logic                w_rd_acc;
    logic                w_wr_acc;
    logic                w_rmw_acc;
    logic                w_access;
    logic                w_err;
    logic                w_blocked;
    logic                w_mem_we;
    logic [71:0]         w_mem_wdata;
    logic [ADDR_W-1:0]   w_addr_next;

    // Word at the current address; {tag, data}. Read asynchronously so the
    // protection check and the read data are available in the strobe cycle.
    assign w_word = r_mem[r_addr];

    // Only the low index bits advance, so a burst wraps inside its block.
    generate
        if (c_IDX_W > 0) begin : g_wrap
            localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);
            assign w_addr_next = {r_addr[ADDR_W-1:c_IDX_W],
                                  r_addr[c_IDX_W-1:0] + c_IDX_ONE};
        end else begin : g_single
            assign w_addr_next = r_addr;
        end
    endgenerate

    // Decode the strobes into access and error qualifiers.
    always_comb begin
        w_armed_free = (r_state == S_ARMED) && !i_astb;
        w_rd_acc     = w_armed_free && i_rd && !i_wr;
        w_wr_acc     = w_armed_free && i_wr && !i_rd;
`ifdef TMEM_RDMWR_EN
        w_rmw_acc    = w_armed_free && i_rd && i_wr;
`else
        w_rmw_acc    = 1'b0;
`endif
        w_access     = w_rd_acc || w_wr_acc || w_rmw_acc;
        // A strobe with an address, with no address, or an unsupported
        // rd+wr combination is a protocol error.
        w_err        = (i_astb && (i_rd || i_wr))
                    || ((r_state == S_IDLE) && (i_rd || i_wr))
                    || (w_armed_free && i_rd && i_wr && !w_rmw_acc);
        w_blocked    = w_word[64 + PROT_BIT] && !i_wforce;
        w_mem_we     = (w_wr_acc || w_rmw_acc) && !w_blocked;
        w_mem_wdata  = w_rmw_acc ? {w_word[71:64], w_word[63:0] | c_RMW_MASK}
                                 : {i_tag, i_ad};
    end

    // RAM write port; contents are not reset, and a write that coincides
    // with reset is dropped.
    always_ff @(posedge clk) begin
        if (w_mem_we && !reset) begin
            r_mem[r_addr] <= w_mem_wdata;
        end
    end

    // Control FSM with registered read data and status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_cnt    <= '0;
            o_data   <= '0;
            o_tag    <= '0;
            o_rvalid <= 1'b0;
            o_wprot  <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            o_rvalid <= 1'b0;
            o_wprot  <= 1'b0;
            o_err    <= w_err;

            if (w_rd_acc || w_rmw_acc) begin
                o_data   <= w_word[63:0];
                o_tag    <= w_word[71:64];
                o_rvalid <= 1'b1;
            end

            if ((w_wr_acc || w_rmw_acc) && w_blocked) begin
                o_wprot <= 1'b1;
            end

            if (i_astb) begin
                r_addr  <= i_ad[ADDR_W-1:0];
                r_cnt   <= '0;
                r_state <= S_ARMED;
            end else if (w_access) begin
                // Blocked writes still consume a burst slot.
                r_addr <= w_addr_next;
                if (r_cnt == c_CNT_LAST) begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end else begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire
